// File: rtl/cache_way_array.sv
// cache_way_array: N-way tag/status/data arrays, 1-cycle lookup with
// write-first forwarding, per-set round-robin victim and flush sweep.
// Ports: lk_* lookup in, rsp_* registered result out, wr_* way write
// (tag+status, per-word data), flush_req in / busy out while sweeping.
module cache_way_array #(
  parameter int TAG_LEN    = 13,
  parameter int INDEX_LEN  = 10,
  parameter int OFFSET_LEN = 4,
  parameter int WAYS       = 2,
  parameter int STATUS_LEN = 3,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int WORDS  = 1 << (OFFSET_LEN - 2),
  localparam int LINE_W = 32 * WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lk_valid,
  input  logic [INDEX_LEN-1:0]  lk_index,
  input  logic [TAG_LEN-1:0]    lk_tag,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic [STATUS_LEN-1:0] rsp_status,
  output logic [LINE_W-1:0]     rsp_data,
  output logic [WAY_W-1:0]      rsp_victim,
  input  logic                  wr_en,
  input  logic [WAY_W-1:0]      wr_way,
  input  logic [INDEX_LEN-1:0]  wr_index,
  input  logic                  wr_tag_en,
  input  logic [TAG_LEN-1:0]    wr_tag,
  input  logic [STATUS_LEN-1:0] wr_status,
  input  logic [WORDS-1:0]      wr_word_en,
  input  logic [LINE_W-1:0]     wr_data,
  input  logic                  flush_req,
  output logic                  busy
);
  localparam int SETS = 1 << INDEX_LEN;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state, state_nx;
  logic                 init_pend;
  logic [INDEX_LEN-1:0] cnt;
  logic                 lk_go, wr_go, same_idx;

  assign busy     = (state == SWEEP);
  assign lk_go    = lk_valid & ~busy;
  assign wr_go    = wr_en & ~busy;
  assign same_idx = wr_go && (wr_index == lk_index);

  // init_pend forces the first sweep after reset without flush_req
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (flush_req || init_pend) state_nx = SWEEP;
      SWEEP: if (cnt == '1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      init_pend <= 1'b1;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      init_pend <= 1'b0;
      cnt       <= busy ? cnt + 1'b1 : '0;
    end
  end

  logic [WAY_W-1:0] rr [SETS];
  logic [WAY_W-1:0] rr_next;

  assign rr_next = (wr_way == WAY_W'(WAYS - 1)) ? '0 : wr_way + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) rr[i] <= '0;
    end else if (busy) begin
      rr[cnt] <= '0;
    end else if (wr_go && wr_tag_en) begin
      rr[wr_index] <= rr_next;
    end
  end

  logic                  v_q;
  logic [WAY_W-1:0]      vic_q;
  logic [TAG_LEN-1:0]    tag_q;
  logic [WAY_W-1:0]      fw_way;
  logic                  fw_tag_en;
  logic [WORDS-1:0]      fw_words;
  logic [TAG_LEN-1:0]    fw_tag;
  logic [STATUS_LEN-1:0] fw_status;
  logic [LINE_W-1:0]     fw_data;

  // fw_* capture a same-index write so the result can be merged
  // over the (read-before-write) RAM output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= 1'b0;
      vic_q     <= '0;
      fw_way    <= '0;
      fw_tag_en <= 1'b0;
      fw_words  <= '0;
    end else begin
      v_q <= lk_go;
      if (lk_go) begin
        vic_q     <= rr[lk_index];
        fw_way    <= wr_way;
        fw_tag_en <= same_idx & wr_tag_en;
        fw_words  <= same_idx ? wr_word_en : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lk_go) begin
      tag_q     <= lk_tag;
      fw_tag    <= wr_tag;
      fw_status <= wr_status;
      fw_data   <= wr_data;
    end
  end

  logic [WAYS-1:0]                 hit_all;
  logic [WAYS-1:0][STATUS_LEN-1:0] st_all;
  logic [WAYS-1:0][LINE_W-1:0]     d_all;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [STATUS_LEN-1:0] st_mem  [SETS];
    logic [TAG_LEN-1:0]    tag_mem [SETS];
    logic [LINE_W-1:0]     d_mem   [SETS];
    logic [STATUS_LEN-1:0] st_rd, m_st;
    logic [TAG_LEN-1:0]    tag_rd, m_tag;
    logic [LINE_W-1:0]     d_rd, m_d;
    logic                  sel_wr, sel_fw;

    assign sel_wr = wr_go && (wr_way == WAY_W'(w));
    assign sel_fw = (fw_way == WAY_W'(w));

    always_ff @(posedge clk) begin
      if (busy) st_mem[cnt] <= '0;
      else if (sel_wr && wr_tag_en) st_mem[wr_index] <= wr_status;
      if (lk_go) st_rd <= st_mem[lk_index];
    end

    always_ff @(posedge clk) begin
      if (sel_wr && wr_tag_en) tag_mem[wr_index] <= wr_tag;
      if (lk_go) tag_rd <= tag_mem[lk_index];
    end

    always_ff @(posedge clk) begin
      for (int k = 0; k < WORDS; k++)
        if (sel_wr && wr_word_en[k])
          d_mem[wr_index][32*k +: 32] <= wr_data[32*k +: 32];
      if (lk_go) d_rd <= d_mem[lk_index];
    end

    always_comb begin
      m_st  = st_rd;
      m_tag = tag_rd;
      m_d   = d_rd;
      if (sel_fw && fw_tag_en) begin
        m_st  = fw_status;
        m_tag = fw_tag;
      end
      for (int k = 0; k < WORDS; k++)
        if (sel_fw && fw_words[k])
          m_d[32*k +: 32] = fw_data[32*k +: 32];
    end

    assign hit_all[w] = m_st[0] && (m_tag == tag_q);
    assign st_all[w]  = m_st;
    assign d_all[w]   = m_d;
  end

  // descending scan so the lowest hitting way wins
  always_comb begin
    rsp_hit    = 1'b0;
    rsp_way    = '0;
    rsp_status = '0;
    rsp_data   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (v_q && hit_all[w]) begin
        rsp_hit    = 1'b1;
        rsp_way    = WAY_W'(w);
        rsp_status = st_all[w];
        rsp_data   = d_all[w];
      end
    end
  end

  assign rsp_valid  = v_q;
  assign rsp_victim = v_q ? vic_q : '0;

endmodule

// File: tb/tb_cache_way_array.sv
// tb_cache_way_array: directed scoreboard bench for cache_way_array
// (default parameters: 2 ways, 1024 sets, 4-word lines).
module tb_cache_way_array;
  localparam int SETS = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lk_valid = 1'b0;
  logic [9:0]   lk_index = '0;
  logic [12:0]  lk_tag = '0;
  logic         rsp_valid, rsp_hit;
  logic [0:0]   rsp_way, rsp_victim;
  logic [2:0]   rsp_status;
  logic [127:0] rsp_data;
  logic         wr_en = 1'b0;
  logic [0:0]   wr_way = '0;
  logic [9:0]   wr_index = '0;
  logic         wr_tag_en = 1'b0;
  logic [12:0]  wr_tag = '0;
  logic [2:0]   wr_status = '0;
  logic [3:0]   wr_word_en = '0;
  logic [127:0] wr_data = '0;
  logic         flush_req = 1'b0;
  logic         busy;

  cache_way_array dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_status(rsp_status), .rsp_data(rsp_data),
    .rsp_victim(rsp_victim),
    .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index),
    .wr_tag_en(wr_tag_en), .wr_tag(wr_tag), .wr_status(wr_status),
    .wr_word_en(wr_word_en), .wr_data(wr_data),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         hit;
    logic [0:0]   way;
    logic [2:0]   status;
    logic [127:0] data;
    logic [0:0]   victim;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] A5  = {4{32'hA5A5A5A5}};
  localparam logic [127:0] D1  = 128'hA5A5A5A5_A5A5A5A5_DEADBEEF_A5A5A5A5;
  localparam logic [127:0] D9A = 128'h90000003_90000002_90000001_90000000;
  localparam logic [127:0] D9B = 128'h91000003_91000002_91000001_91000000;
  localparam logic [127:0] D5B = 128'h50000003_50000002_50000001_50000000;
  localparam logic [127:0] D5C = 128'h50000003_CAFEF00D_50000001_50000000;
  localparam logic [127:0] D20 = 128'h20000003_20000002_20000001_20000000;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 128'(rsp_valid), 128'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_hit", 128'(rsp_hit), 128'(e.hit));
        chk("rsp_way", 128'(rsp_way), 128'(e.way));
        chk("rsp_status", 128'(rsp_status), 128'(e.status));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_victim", 128'(rsp_victim), 128'(e.victim));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    lk_valid   = 1'b0;
    wr_en      = 1'b0;
    wr_tag_en  = 1'b0;
    wr_word_en = '0;
    flush_req  = 1'b0;
  endtask

  task automatic probe(input logic [9:0] idx, input logic [12:0] tag);
    lk_valid = 1'b1;
    lk_index = idx;
    lk_tag   = tag;
  endtask

  task automatic lk(input logic [9:0] idx, input logic [12:0] tag,
                    input logic h, input logic [0:0] w,
                    input logic [2:0] st, input logic [127:0] d,
                    input logic [0:0] vic);
    exp_t x;
    probe(idx, tag);
    x.hit = h; x.way = w; x.status = st; x.data = d; x.victim = vic;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [0:0] w, input logic [9:0] idx,
                    input logic ten, input logic [12:0] tag,
                    input logic [2:0] st, input logic [3:0] wen,
                    input logic [127:0] d);
    wr_en      = 1'b1;
    wr_way     = w;
    wr_index   = idx;
    wr_tag_en  = ten;
    wr_tag     = tag;
    wr_status  = st;
    wr_word_en = wen;
    wr_data    = d;
  endtask

  task automatic count_sweep(string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(name, 128'(n), 128'(SETS));
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(name, 128'(busy), 128'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_hit", 128'(rsp_hit), 128'd0);
    chk("rst_rsp_victim", 128'(rsp_victim), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    rst = 1'b0;
    count_sweep("init_sweep_len");

    lk(10'd5, 13'h123, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0);
    step();
    wr(1'b1, 10'd5, 1'b1, 13'h123, 3'b001, 4'b1111, A5);
    step();
    lk(10'd5, 13'h123, 1'b1, 1'b1, 3'b001, A5, 1'b0);
    step();
    lk(10'd5, 13'h124, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0);
    step();
    wr(1'b1, 10'd5, 1'b0, 13'h0, 3'd0, 4'b0010,
       128'h11111111_22222222_DEADBEEF_33333333);
    step();
    lk(10'd5, 13'h123, 1'b1, 1'b1, 3'b001, D1, 1'b0);
    step();
    wr(1'b0, 10'd9, 1'b1, 13'h55, 3'b101, 4'b1111, D9A);
    step();
    lk(10'd9, 13'h55, 1'b1, 1'b0, 3'b101, D9A, 1'b1);
    step();

    wr(1'b0, 10'd5, 1'b1, 13'h7, 3'b011, 4'b1111, D5B);
    lk(10'd5, 13'h7, 1'b1, 1'b0, 3'b011, D5B, 1'b0);
    step();
    wr(1'b0, 10'd5, 1'b0, 13'h0, 3'd0, 4'b0100,
       128'h77777777_CAFEF00D_66666666_44444444);
    lk(10'd5, 13'h7, 1'b1, 1'b0, 3'b011, D5C, 1'b1);
    step();
    lk(10'd5, 13'h7, 1'b1, 1'b0, 3'b011, D5C, 1'b1);
    step();
    lk(10'd5, 13'h123, 1'b1, 1'b1, 3'b001, D1, 1'b1);
    step();

    wr(1'b1, 10'd9, 1'b1, 13'h55, 3'b001, 4'b1111, D9B);
    step();
    lk(10'd9, 13'h55, 1'b1, 1'b0, 3'b101, D9A, 1'b0);
    step();
    wr(1'b0, 10'd20, 1'b1, 13'h20, 3'b001, 4'b1111, D20);
    lk(10'd9, 13'h55, 1'b1, 1'b0, 3'b101, D9A, 1'b0);
    step();
    lk(10'd20, 13'h20, 1'b1, 1'b0, 3'b001, D20, 1'b1);
    step();
    wr(1'b0, 10'd30, 1'b1, 13'h30, 3'b110, 4'b1111, D20);
    step();
    lk(10'd30, 13'h30, 1'b0, 1'b0, 3'd0, 128'd0, 1'b1);
    step();

    flush_req = 1'b1;
    step();
    chk("flush_busy", 128'(busy), 128'd1);
    probe(10'd5, 13'h7);
    step();
    chk("busy_rsp_valid", 128'(rsp_valid), 128'd0);
    wait_idle("flush_done");
    lk(10'd5, 13'h7, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0);
    step();
    lk(10'd9, 13'h55, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0);
    step();
    lk(10'd20, 13'h20, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0);
    step();
    step();

    wr(1'b0, 10'd20, 1'b1, 13'h20, 3'b001, 4'b1111, D20);
    step();
    flush_req = 1'b1;
    step();
    repeat (100) @(negedge clk);
    chk("mid_sweep_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_rsp_valid", 128'(rsp_valid), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    count_sweep("restart_sweep_len");
    lk(10'd20, 13'h20, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0);
    step();
    step();
    step();

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_way_array.md
CACHE_WAY_ARRAY -- requirements
Module: cache_way_array

Interface
REQ-001 SHALL have parameter TAG_LEN, default 13, tag width in bits.
REQ-002 SHALL have parameter INDEX_LEN, default 10, set index width; sets = 2**INDEX_LEN.
REQ-003 SHALL have parameter OFFSET_LEN, default 4, line offset width; words per line WORDS = 2**(OFFSET_LEN-2); LINE_W = 32*WORDS.
REQ-004 SHALL have parameter WAYS, default 2, associativity (power of two, 1..8); WAY_W = max(1, clog2(WAYS)).
REQ-005 SHALL have parameter STATUS_LEN, default 3, status width; status bit 0 = valid.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 lk_valid  in  1  lookup request strobe; lk_index  in  INDEX_LEN  lookup set; lk_tag  in  TAG_LEN  lookup tag.
REQ-009 rsp_valid  out  1  lookup result valid; rsp_hit  out  1  hit flag; rsp_way  out  WAY_W  hit way; rsp_status  out  STATUS_LEN  hit-way status; rsp_data  out  LINE_W  hit-way line; rsp_victim  out  WAY_W  replacement way for the set.
REQ-010 wr_en  in  1  write strobe; wr_way  in  WAY_W; wr_index  in  INDEX_LEN; wr_tag_en  in  1  write tag+status; wr_tag  in  TAG_LEN; wr_status  in  STATUS_LEN; wr_word_en  in  WORDS  per-32-bit-word data enable; wr_data  in  LINE_W.
REQ-011 flush_req  in  1  start invalidate-all; busy  out  1  flush sweep in progress.

Function
REQ-012 Per way: tag/status array and data array, each one synchronous-read block RAM of 2**INDEX_LEN entries; RAM contents SHALL not be cleared by rst (invalidation via sweep only).
REQ-013 Lookup latency 1 cycle: lk_valid at edge N -> rsp_valid=1 during cycle N+1 only, unless lk_valid repeats; back-to-back lookups SHALL be accepted every cycle.
REQ-014 Hit for way w: status[0]=1 and stored tag == lk_tag; rsp_hit = OR over ways; rsp_way = lowest hitting way; rsp_status/rsp_data = that way's contents.
REQ-015 On miss: rsp_hit=0, rsp_way=0, rsp_status=0, rsp_data=0.
REQ-016 rsp_victim SHALL equal the set's round-robin pointer sampled with the lookup; pointer (WAY_W bits per set, flip-flops) advances to (wr_way+1) mod WAYS on every write with wr_tag_en=1; wraps WAYS-1 -> 0.
REQ-017 Write: wr_en with wr_tag_en writes {wr_status, wr_tag}; each set wr_word_en[k] writes word k of wr_data; unset words retain old value; completes at the same edge.
REQ-018 Lookup and write same cycle, same index: response SHALL reflect post-write contents of wr_way (write-first, per-word merge); other ways return stored contents.
REQ-019 Same cycle, different index: both complete independently.
REQ-020 Flush FSM states IDLE, SWEEP: IDLE->SWEEP on flush_req=1; SWEEP writes status=0 to all ways of one index per cycle from 0 upward and clears that set's pointer; SWEEP->IDLE after index 2**INDEX_LEN-1; sweep lasts exactly 2**INDEX_LEN cycles.
REQ-021 busy=1 throughout SWEEP; while busy, lk_valid, wr_en and flush_req SHALL be ignored and rsp_valid held 0.
REQ-022 Tags and data SHALL be left unchanged by the sweep.

Reset
REQ-023 rst=1 SHALL immediately force rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_status=0, rsp_data=0, rsp_victim=0, busy=0, all round-robin pointers 0, FSM IDLE.
REQ-024 After rst deasserts, the block SHALL enter SWEEP automatically at the first clock edge (busy=1), so every entry is invalid before first use.
REQ-025 rst asserted mid-sweep SHALL abort; the post-reset sweep restarts from index 0.

Verification
REQ-026 Reset, wait 2**INDEX_LEN cycles -> busy falls; lookup index 5 tag 0x123 -> rsp_valid=1, rsp_hit=0, rsp_victim=0.
REQ-027 Write way 1 index 5 tag 0x123 status 3'b001 data all 0xA5, then lookup -> rsp_hit=1, rsp_way=1, rsp_data all 0xA5, rsp_victim=0 (pointer 1+1 wraps to 0 for WAYS=2).
REQ-028 wr_word_en=4'b0010 data word1=0xDEADBEEF to that line -> next lookup: word1=0xDEADBEEF, words 0,2,3 still 0xA5A5A5A5.
REQ-029 Lookup and write same index same cycle, new tag 0x7 way 0 -> rsp_hit=1, rsp_way=0 for lk_tag 0x7.
REQ-030 flush_req after fills, lookup during busy -> rsp_valid=0; after sweep same lookup -> rsp_hit=0; rst pulse mid-sweep -> busy 0 immediately, then full 2**INDEX_LEN-cycle sweep.
